// File: rtl/ctrl_pkg.sv
// Shared sequencer definitions: state encoding, instruction field constants,
// write-back / PC-select encodings and the instruction class decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_CMP,
        C_JAL,
        C_JCOND,
        C_LOAD,
        C_STOR,
        C_ILLEGAL
    } iclass_t;

    // Primary opcode, inst[15:12]
    localparam logic [3:0] OP_REG   = 4'h0;
    localparam logic [3:0] OP_ANDI  = 4'h1;
    localparam logic [3:0] OP_ORI   = 4'h2;
    localparam logic [3:0] OP_XORI  = 4'h3;
    localparam logic [3:0] OP_MEM   = 4'h4;
    localparam logic [3:0] OP_ADDI  = 4'h5;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_SUBI  = 4'h9;
    localparam logic [3:0] OP_CMPI  = 4'hB;
    localparam logic [3:0] OP_MOVI  = 4'hD;
    localparam logic [3:0] OP_LUI   = 4'hF;

    // Opcode extension, inst[7:4]
    localparam logic [3:0] EXT_AND   = 4'h1;
    localparam logic [3:0] EXT_OR    = 4'h2;
    localparam logic [3:0] EXT_XOR   = 4'h3;
    localparam logic [3:0] EXT_NOT   = 4'h4;
    localparam logic [3:0] EXT_ADD   = 4'h5;
    localparam logic [3:0] EXT_JAL   = 4'h8;
    localparam logic [3:0] EXT_SUB   = 4'h9;
    localparam logic [3:0] EXT_CMP   = 4'hB;
    localparam logic [3:0] EXT_JCOND = 4'hC;
    localparam logic [3:0] EXT_MOV   = 4'hD;
    localparam logic [3:0] EXT_LOAD  = 4'h0;
    localparam logic [3:0] EXT_STOR  = 4'h4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC1 = 2'd2;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_TGT = 2'd1;

    function automatic logic [3:0] op_field(input logic [15:0] word);
        return word[15:12];
    endfunction

    function automatic logic [3:0] ext_field(input logic [15:0] word);
        return word[7:4];
    endfunction

    // CMP/CMPI only update flags; they are kept apart from the write-back ALU class.
    function automatic iclass_t decode_class(input logic [3:0] op, input logic [3:0] ext);
        iclass_t c;
        c = C_ILLEGAL;
        case (op)
            OP_REG: begin
                case (ext)
                    EXT_AND, EXT_OR, EXT_XOR, EXT_NOT,
                    EXT_ADD, EXT_SUB, EXT_MOV:          c = C_ALU;
                    EXT_CMP:                            c = C_CMP;
                    EXT_JAL:                            c = C_JAL;
                    EXT_JCOND:                          c = C_JCOND;
                    default:                            c = C_ILLEGAL;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI,
            OP_SUBI, OP_MOVI, OP_LUI, OP_SHIFT:         c = C_ALU;
            OP_CMPI:                                    c = C_CMP;
            OP_MEM: begin
                if (ext == EXT_LOAD)      c = C_LOAD;
                else if (ext == EXT_STOR) c = C_STOR;
                else                      c = C_ILLEGAL;
            end
            default:                                    c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic sets_flags(input logic [3:0] op, input logic [3:0] ext);
        return ((op == OP_REG) && (ext == EXT_ADD || ext == EXT_SUB || ext == EXT_CMP)) ||
               (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI);
    endfunction

endpackage

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// handshake watchdog that parks the machine in HALT until reset.
module seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        cond_true,
    output logic        ir_we,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        flags_we,
    output logic        illegal,
    output logic        halted
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t           state;
    logic [3:0]       ir_op;
    logic [3:0]       ir_ext;
    logic [CNT_W-1:0] wait_cnt;
    iclass_t          cls;
    logic             flag_op;
    logic             wait_limit;
    logic             unused_inst;

    // Condition and register fields are consumed by the datapath, not here.
    assign unused_inst = ^{inst[11:8], inst[3:0]};

    assign cls        = decode_class(ir_op, ir_ext);
    assign flag_op    = sets_flags(ir_op, ir_ext);
    assign wait_limit = (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir_op    <= op_field(inst);
                        ir_ext   <= ext_field(inst);
                        state    <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (wait_limit) begin
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: state <= S_EXEC;
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (cls == C_LOAD || cls == C_STOR) state <= S_MEM;
                    else                                state <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        wait_cnt <= '0;
                        state    <= (cls == C_LOAD) ? S_WB : S_FETCH;
                    end else if (wait_limit) begin
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    wait_cnt <= '0;
                    state    <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    // Outputs are held low while rst is high so nothing commits on the reset edge.
    always_comb begin
        ir_we    = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_INC;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        flags_we = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    case (cls)
                        C_ALU: begin
                            rf_we    = 1'b1;
                            pc_we    = 1'b1;
                            flags_we = flag_op;
                        end
                        C_CMP: begin
                            pc_we    = 1'b1;
                            flags_we = 1'b1;
                        end
                        C_JAL: begin
                            rf_we  = 1'b1;
                            wb_sel = WB_PC1;
                            pc_we  = 1'b1;
                            pc_sel = PC_TGT;
                        end
                        C_JCOND: begin
                            pc_we  = 1'b1;
                            pc_sel = cond_true ? PC_TGT : PC_INC;
                        end
                        C_LOAD, C_STOR: ;
                        default: begin
                            illegal = 1'b1;
                            pc_we   = 1'b1;
                        end
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (cls == C_STOR);
                    pc_we    = dmem_ready && (cls == C_STOR);
                end
                S_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = WB_MEM;
                    pc_we  = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: max wait cycles for any memory handshake before timeout.
REQ-002 SHALL use one clock; reset synchronous, active-high: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 inst  input  16  instruction word from imem, valid when imem_ready=1.
REQ-005 imem_ready  input  1  imem returns inst this cycle.
REQ-006 dmem_ready  input  1  dmem completes current access this cycle.
REQ-007 cond_true  input  1  flag unit reports condition in inst[11:8] met.
REQ-008 ir_we  output  1  load instruction register.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 dmem_req  output  1  data access request.
REQ-011 dmem_we  output  1  data access is a write.
REQ-012 pc_we  output  1  update PC.
REQ-013 pc_sel  output  2  0=PC+1, 1=Rsrc target.
REQ-014 rf_we  output  1  register file write enable.
REQ-015 wb_sel  output  2  0=ALU, 1=dmem data, 2=PC+1.
REQ-016 flags_we  output  1  latch ALU flags.
REQ-017 illegal  output  1  one-cycle pulse on undefined encoding.
REQ-018 halted  output  1  sequencer stuck in HALT after timeout.

Function
REQ-019 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT; state enum value exported on no port.
REQ-020 FETCH: imem_req=1; on imem_ready, ir_we=1 for that cycle, go to DECODE; else stay.
REQ-021 DECODE: one cycle, no enables asserted, go to EXEC.
REQ-022 EXEC, ALU classes (opcode 0 ext 1,2,3,4,5,9,D; opcodes 1,2,3,5,9,D,F; opcode 8): rf_we=1, wb_sel=0, pc_we=1, pc_sel=0, go to FETCH.
REQ-023 EXEC, ADD/ADDI/SUB/SUBI/CMP/CMPI: flags_we=1; CMP/CMPI: rf_we=0.
REQ-024 EXEC, JAL (opcode 0 ext 8): rf_we=1, wb_sel=2, pc_we=1, pc_sel=1.
REQ-025 EXEC, JCOND (opcode 0 ext C): pc_we=1, pc_sel=1 if cond_true else pc_sel=0; rf_we=0.
REQ-026 EXEC, LOAD (opcode 4 ext 0) / STOR (opcode 4 ext 4): no enables, go to MEM.
REQ-027 MEM: dmem_req=1, dmem_we=1 iff STOR; on dmem_ready, LOAD goes to WB, STOR asserts pc_we (pc_sel=0) and goes to FETCH.
REQ-028 WB: rf_we=1, wb_sel=1, pc_we=1, pc_sel=0, go to FETCH.
REQ-029 Any other encoding in EXEC: illegal=1, pc_we=1, pc_sel=0, no other enables, go to FETCH.
REQ-030 Wait counter: clears on entering FETCH or MEM, increments each cycle ready is low; reaching MEM_WAIT_MAX with ready low enters HALT; ready on the same cycle as the limit wins.
REQ-031 HALT: all enables 0, halted=1, left only by rst.
REQ-032 Latency with zero-wait memory: ALU/JAL/JCOND 3 cycles, STOR 4, LOAD 5; exactly one pc_we per instruction.
REQ-033 All outputs combinational from state, registered opcode fields and ready inputs; no enable asserted outside listed states.

Reset
REQ-034 rst=1 at any edge, including mid-MEM or in HALT: state=FETCH, wait counter=0, all outputs 0 except imem_req=1 in the first post-reset cycle; no write completes on the reset edge.

Structure
REQ-035 State enum, opcode/op_ext constants and wb_sel/pc_sel encodings SHALL live in shared package ctrl_pkg, also used by the decoder.
REQ-036 Single module; field extraction shared with decoder via ctrl_pkg constants, no new sub-module.

Verification
REQ-037 ADD (inst 0x0253), imem_ready=1 -> ir_we at cycle 1, rf_we+flags_we+pc_we at cycle 3, wb_sel=0.
REQ-038 LOAD (0x4203), dmem_ready after 2 wait cycles -> dmem_req 3 cycles, dmem_we=0, WB rf_we with wb_sel=1, total 7 cycles.
REQ-039 STOR (0x4243) -> dmem_we=1 with dmem_req, rf_we never asserted, pc_we on dmem_ready cycle.
REQ-040 JCOND (0x02C3) cond_true=1 -> pc_sel=1; cond_true=0 -> pc_sel=0; JAL (0x0283) -> rf_we, wb_sel=2, pc_sel=1.
REQ-041 imem_ready held 0 for 15 cycles -> halted=1, no enables; rst pulse -> FETCH, halted=0.
REQ-042 Illegal 0x6000 -> illegal pulse one cycle, PC advances, no rf_we; rst asserted during MEM of a STOR -> no further dmem_req after reset edge.
